psum_bank_array: RTL and testbench

Partial-sum storage and accumulate datapath sitting directly downstream of `psum_manager`. It holds the small and big psum banks, accepts result words from the compute array, and commits them to the bank/address the manager selects. During reduction it reads the previous psum from the manager's read bank, adds it, and writes the sum to the new write bank. It returns `write_enable` to the manager on every accepted word, and provides a drain read port so the controller can fetch finished psums.

---
 rtl/psum_pkg.sv | 19 +
 rtl/psum_bank_ram.sv | 32 +++
 rtl/psum_bank_array.sv | 177 +++++++++++++++++
 tb/tb_psum_bank_array.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared psum storage types and bank geometry constants, common to psum_manager and psum_bank_array.
// The saturating-add build option PSUM_SATURATE_EN is consumed by psum_bank_array.
package psum_pkg;

  localparam int SMALL_BANK_COUNT = 3;
  localparam int BIG_BANK_COUNT   = 3;
  localparam int TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT;
  localparam int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT);
  localparam int SMALL_DEPTH      = 16;
  localparam int ADDR_WIDTH       = 8;
  localparam int DATA_WIDTH       = 32;

  typedef logic [DATA_WIDTH-1:0]       psum_t;
  typedef logic [BANK_INDEX_WIDTH-1:0] bank_idx_t;

  // All-ones index is what the manager drives when it has no bank to offer.
  localparam bank_idx_t NO_BANK = '1;

endpackage

// File: rtl/psum_bank_ram.sv
// One psum bank: synchronous RAM with one write port and one registered read port.
// Contents are deliberately not reset.
module psum_bank_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Read-first: a read and write to the same word in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/psum_bank_array.sv
// Psum bank storage with accumulate (read-modify-write) pipeline, forwarding and drain port.
// Define PSUM_SATURATE_EN to make the accumulate add saturate instead of wrap.
module psum_bank_array #(
  parameter int SMALL_BANK_COUNT = psum_pkg::SMALL_BANK_COUNT,
  parameter int BIG_BANK_COUNT   = psum_pkg::BIG_BANK_COUNT,
  parameter int TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT,
  parameter int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT),
  parameter int SMALL_DEPTH      = psum_pkg::SMALL_DEPTH,
  parameter int ADDR_WIDTH       = psum_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH       = psum_pkg::DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  input  logic                        stall,
  input  logic [BANK_INDEX_WIDTH-1:0] write_bank_index,
  input  logic [ADDR_WIDTH-1:0]       write_address,
  input  logic [BANK_INDEX_WIDTH-1:0] read_bank_index,
  input  logic [ADDR_WIDTH-1:0]       read_address,
  input  logic                        read_bank_valid,
  output logic                        write_enable,
  input  logic                        dr_req,
  input  logic [BANK_INDEX_WIDTH-1:0] dr_bank,
  input  logic [ADDR_WIDTH-1:0]       dr_addr,
  output logic                        dr_valid,
  output logic [DATA_WIDTH-1:0]       dr_data,
  output logic                        err
);

  function automatic logic bank_ok(input logic [BANK_INDEX_WIDTH-1:0] b);
    return 32'(b) < TOTAL_BANK_COUNT;
  endfunction

  function automatic logic addr_ok(input logic [BANK_INDEX_WIDTH-1:0] b,
                                   input logic [ADDR_WIDTH-1:0] a);
    return (32'(b) >= SMALL_BANK_COUNT) || (32'(a) < SMALL_DEPTH);
  endfunction

  // Stage A: accept and error classification
  logic accept;
  logic w_ok, r_ok, a_err, a_rbv_eff;
  logic dr_ok;

  assign in_ready     = !stall && !dr_req && !reset;
  assign write_enable = in_valid && in_ready;
  assign accept       = write_enable;

  assign w_ok      = bank_ok(write_bank_index) && addr_ok(write_bank_index, write_address);
  assign r_ok      = bank_ok(read_bank_index) && addr_ok(read_bank_index, read_address);
  assign a_err     = !w_ok || (read_bank_valid && (!r_ok || (read_bank_index == write_bank_index)));
  assign a_rbv_eff = read_bank_valid && r_ok;
  assign dr_ok     = bank_ok(dr_bank) && addr_ok(dr_bank, dr_addr);

  // Shared RAM read port: drain wins; a new word is never accepted while dr_req is high.
  logic                        rd_en;
  logic [BANK_INDEX_WIDTH-1:0] rd_bank;
  logic [ADDR_WIDTH-1:0]       rd_addr;

  assign rd_en   = dr_req ? dr_ok : (accept && a_rbv_eff);
  assign rd_bank = dr_req ? dr_bank : read_bank_index;
  assign rd_addr = dr_req ? dr_addr : read_address;

  // Stage B state
  logic                        b_wr_reg;
  logic                        b_err_reg;
  logic                        b_rbv_reg;
  logic                        fwd_reg;
  logic [DATA_WIDTH-1:0]       fwd_data_reg;
  logic [DATA_WIDTH-1:0]       b_data_reg;
  logic [BANK_INDEX_WIDTH-1:0] b_bank_reg;
  logic [ADDR_WIDTH-1:0]       b_addr_reg;
  logic [BANK_INDEX_WIDTH-1:0] b_rbank_reg;

  logic                        dr_valid_reg;
  logic                        dr_ok_reg;
  logic                        dr_err_reg;
  logic [BANK_INDEX_WIDTH-1:0] dr_bank_reg;

  logic [DATA_WIDTH-1:0] bank_rdata [TOTAL_BANK_COUNT];
  logic [DATA_WIDTH-1:0] b_rd_mux;
  logic [DATA_WIDTH-1:0] dr_rd_mux;
  logic [DATA_WIDTH-1:0] prev_psum;
  logic [DATA_WIDTH-1:0] raw_sum;
  logic [DATA_WIDTH-1:0] sum_b;
  logic                  fwd_hit;

  always_comb begin
    b_rd_mux  = '0;
    dr_rd_mux = '0;
    for (int i = 0; i < TOTAL_BANK_COUNT; i++) begin
      if (32'(b_rbank_reg) == i) b_rd_mux = bank_rdata[i];
      if (32'(dr_bank_reg) == i) dr_rd_mux = bank_rdata[i];
    end
  end

  assign prev_psum = b_rbv_reg ? (fwd_reg ? fwd_data_reg : b_rd_mux) : '0;
  assign raw_sum   = b_data_reg + prev_psum;

`ifdef PSUM_SATURATE_EN
  logic sat_ovf;
  assign sat_ovf = (b_data_reg[DATA_WIDTH-1] == prev_psum[DATA_WIDTH-1]) &&
                   (raw_sum[DATA_WIDTH-1] != b_data_reg[DATA_WIDTH-1]);
  assign sum_b   = !sat_ovf ? raw_sum :
                   b_data_reg[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign sum_b = raw_sum;
`endif

  // The RAM read issued this cycle would miss the word stage B is writing right now.
  assign fwd_hit = b_wr_reg && a_rbv_eff &&
                   (read_bank_index == b_bank_reg) && (read_address == b_addr_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      b_wr_reg     <= 1'b0;
      b_err_reg    <= 1'b0;
      b_rbv_reg    <= 1'b0;
      fwd_reg      <= 1'b0;
      dr_valid_reg <= 1'b0;
      dr_ok_reg    <= 1'b0;
      dr_err_reg   <= 1'b0;
    end else begin
      b_wr_reg     <= accept && !a_err;
      b_err_reg    <= accept && a_err;
      dr_valid_reg <= dr_req;
      dr_ok_reg    <= dr_req && dr_ok;
      dr_err_reg   <= dr_req && !dr_ok;
      if (dr_req) begin
        dr_bank_reg <= dr_bank;
      end
      if (accept) begin
        b_data_reg   <= in_data;
        b_bank_reg   <= write_bank_index;
        b_addr_reg   <= write_address;
        b_rbank_reg  <= read_bank_index;
        b_rbv_reg    <= a_rbv_eff;
        fwd_reg      <= fwd_hit;
        fwd_data_reg <= sum_b;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_BANK_COUNT; gi++) begin : g_bank
      localparam int DEPTH = (gi < SMALL_BANK_COUNT) ? SMALL_DEPTH : (1 << ADDR_WIDTH);
      localparam int AW    = $clog2(DEPTH);
      logic bank_we;
      logic bank_re;

      // Reset drops any stage-B write that is still pending.
      assign bank_we = b_wr_reg && !reset && (32'(b_bank_reg) == gi);
      assign bank_re = rd_en && (32'(rd_bank) == gi);

      psum_bank_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_ram (
        .clk   (clk),
        .we    (bank_we),
        .waddr (b_addr_reg[AW-1:0]),
        .wdata (sum_b),
        .re    (bank_re),
        .raddr (rd_addr[AW-1:0]),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  assign dr_valid = dr_valid_reg;
  assign dr_data  = (dr_valid_reg && dr_ok_reg) ? dr_rd_mux : '0;
  assign err      = b_err_reg || dr_err_reg;

endmodule

// File: tb/tb_psum_bank_array.sv
// Self-checking bench for psum_bank_array: table of accepts, then drains checked through a scoreboard queue.
module tb_psum_bank_array;
  import psum_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        stall;
  logic [2:0]  write_bank_index;
  logic [7:0]  write_address;
  logic [2:0]  read_bank_index;
  logic [7:0]  read_address;
  logic        read_bank_valid;
  logic        write_enable;
  logic        dr_req;
  logic [2:0]  dr_bank;
  logic [7:0]  dr_addr;
  logic        dr_valid;
  logic [31:0] dr_data;
  logic        err;

  psum_bank_array dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .stall            (stall),
    .write_bank_index (write_bank_index),
    .write_address    (write_address),
    .read_bank_index  (read_bank_index),
    .read_address     (read_address),
    .read_bank_valid  (read_bank_valid),
    .write_enable     (write_enable),
    .dr_req           (dr_req),
    .dr_bank          (dr_bank),
    .dr_addr          (dr_addr),
    .dr_valid         (dr_valid),
    .dr_data          (dr_data),
    .err              (err)
  );

  always #5 clk = ~clk;

`ifdef PSUM_SATURATE_EN
  localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_EXP = 32'h8000_0000;
`endif

  typedef struct {
    logic [31:0] data;
    logic [2:0]  wb;
    logic [7:0]  wa;
    logic        rbv;
    logic [2:0]  rb;
    logic [7:0]  ra;
    logic        exp_err;
    int          gap;
  } acc_vec_t;

  typedef struct {
    logic [2:0]  bank;
    logic [7:0]  addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } dr_vec_t;

  acc_vec_t    acc_tab [16];
  dr_vec_t     dr_tab  [12];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    dr_req   = 1'b0;
    stall    = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic accept(input acc_vec_t v);
    in_valid         = 1'b1;
    in_data          = v.data;
    write_bank_index = v.wb;
    write_address    = v.wa;
    read_bank_valid  = v.rbv;
    read_bank_index  = v.rb;
    read_address     = v.ra;
    #1;
    check("accept_write_enable", {31'd0, write_enable}, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("accept data=%h wb=%0d wa=%0d rbv=%0b rb=%0d ra=%0d err=%0b", v.data, v.wb, v.wa, v.rbv, v.rb, v.ra, err);
    check("accept_err", {31'd0, err}, {31'd0, v.exp_err});
    if (v.gap > 0) begin
      idle(v.gap);
      check("err_one_cycle", {31'd0, err}, 32'd0);
    end
  endtask

  task automatic drain(input dr_vec_t v);
    dr_req  = 1'b1;
    dr_bank = v.bank;
    dr_addr = v.addr;
    exp_q.push_back(v.exp_data);
    tick();
    dr_req = 1'b0;
    $display("drain bank=%0d addr=%0d dr_valid=%0b data=%h err=%0b", v.bank, v.addr, dr_valid, dr_data, err);
    check("drain_valid", {31'd0, dr_valid}, 32'd1);
    check("drain_err", {31'd0, err}, {31'd0, v.exp_err});
  endtask

  // Scoreboard: every dr_valid must match the oldest expected drain word.
  always @(negedge clk) begin
    if (!reset && dr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL drain_unexpected: dr_valid high with data %h, nothing pending", dr_data);
      end else begin
        check("drain_data", dr_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    acc_tab[0]  = '{32'h0000_0005, 3'd0, 8'd0,   1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[1]  = '{32'h0000_0010, 3'd3, 8'd2,   1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[2]  = '{32'h0000_00AB, 3'd2, 8'd15,  1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[3]  = '{32'h0000_0100, 3'd5, 8'd255, 1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[4]  = '{32'h0000_0011, 3'd1, 8'd0,   1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[5]  = '{32'h0000_0022, 3'd2, 8'd1,   1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[6]  = '{32'h7FFF_FFFF, 3'd3, 8'd5,   1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[7]  = '{32'hFFFF_FFFF, 3'd0, 8'd1,   1'b0, NO_BANK, 8'd0, 1'b0, 1};
    acc_tab[8]  = '{32'h0000_0007, 3'd4, 8'd2,   1'b1, 3'd3,    8'd2, 1'b0, 0};
    acc_tab[9]  = '{32'h0000_0001, 3'd4, 8'd5,   1'b1, 3'd3,    8'd5, 1'b0, 0};
    acc_tab[10] = '{32'hFFFF_FFFE, 3'd3, 8'd7,   1'b1, 3'd0,    8'd1, 1'b0, 0};
    acc_tab[11] = '{32'h0000_0003, 3'd4, 8'd0,   1'b0, NO_BANK, 8'd0, 1'b0, 0};
    acc_tab[12] = '{32'h0000_0004, 3'd5, 8'd0,   1'b1, 3'd4,    8'd0, 1'b0, 1};
    acc_tab[13] = '{32'h0000_0099, 3'd1, 8'd16,  1'b0, NO_BANK, 8'd0, 1'b1, 1};
    acc_tab[14] = '{32'h0000_0098, 3'd7, 8'd0,   1'b0, NO_BANK, 8'd0, 1'b1, 1};
    acc_tab[15] = '{32'h0000_0055, 3'd2, 8'd1,   1'b1, 3'd2,    8'd1, 1'b1, 1};

    dr_tab[0]  = '{3'd0, 8'd0,   32'h0000_0005, 1'b0};
    dr_tab[1]  = '{3'd3, 8'd2,   32'h0000_0010, 1'b0};
    dr_tab[2]  = '{3'd2, 8'd15,  32'h0000_00AB, 1'b0};
    dr_tab[3]  = '{3'd5, 8'd255, 32'h0000_0100, 1'b0};
    dr_tab[4]  = '{3'd4, 8'd2,   32'h0000_0017, 1'b0};
    dr_tab[5]  = '{3'd4, 8'd0,   32'h0000_0003, 1'b0};
    dr_tab[6]  = '{3'd5, 8'd0,   32'h0000_0007, 1'b0};
    dr_tab[7]  = '{3'd1, 8'd0,   32'h0000_0011, 1'b0};
    dr_tab[8]  = '{3'd2, 8'd1,   32'h0000_0022, 1'b0};
    dr_tab[9]  = '{3'd4, 8'd5,   OVF_EXP,       1'b0};
    dr_tab[10] = '{3'd3, 8'd7,   32'hFFFF_FFFD, 1'b0};
    dr_tab[11] = '{3'd7, 8'd0,   32'h0000_0000, 1'b1};

    reset            = 1'b1;
    in_valid         = 1'b1;
    in_data          = 32'h0;
    stall            = 1'b0;
    write_bank_index = 3'd0;
    write_address    = 8'd0;
    read_bank_index  = NO_BANK;
    read_address     = 8'd0;
    read_bank_valid  = 1'b0;
    dr_req           = 1'b0;
    dr_bank          = 3'd0;
    dr_addr          = 8'd0;
    for (int k = 0; k < 3; k++) tick();
    $display("reset in_ready=%0b write_enable=%0b dr_valid=%0b err=%0b", in_ready, write_enable, dr_valid, err);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_write_enable", {31'd0, write_enable}, 32'd0);
    check("reset_dr_valid", {31'd0, dr_valid}, 32'd0);
    check("reset_dr_data", dr_data, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    in_valid = 1'b0;
    reset    = 1'b0;
    idle(1);

    for (int i = 0; i < 16; i++) accept(acc_tab[i]);
    idle(2);
    for (int i = 0; i < 12; i++) drain(dr_tab[i]);
    idle(1);

    // Stall, then drain, with a word waiting: nothing may be accepted or written.
    in_valid         = 1'b1;
    in_data          = 32'hDEAD_BEEF;
    write_bank_index = 3'd0;
    write_address    = 8'd0;
    read_bank_valid  = 1'b0;
    stall            = 1'b1;
    #1;
    $display("stall in_ready=%0b write_enable=%0b", in_ready, write_enable);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_write_enable", {31'd0, write_enable}, 32'd0);
    tick();
    stall   = 1'b0;
    dr_req  = 1'b1;
    dr_bank = 3'd0;
    dr_addr = 8'd0;
    exp_q.push_back(32'h0000_0005);
    #1;
    $display("drain_block in_ready=%0b write_enable=%0b", in_ready, write_enable);
    check("drain_in_ready", {31'd0, in_ready}, 32'd0);
    check("drain_write_enable", {31'd0, write_enable}, 32'd0);
    tick();
    in_valid = 1'b0;
    dr_req   = 1'b0;
    check("drain_block_valid", {31'd0, dr_valid}, 32'd1);
    idle(2);
    drain('{3'd0, 8'd0, 32'h0000_0005, 1'b0});

    // Stall rising right after an accept: the in-flight write still lands.
    accept('{32'h0000_0042, 3'd0, 8'd3, 1'b0, NO_BANK, 8'd0, 1'b0, 0});
    in_valid = 1'b1;
    in_data  = 32'h0000_0BAD;
    stall    = 1'b1;
    tick();
    idle(0);
    drain('{3'd0, 8'd3, 32'h0000_0042, 1'b0});
    idle(1);

    // Reset the cycle after an accept: the pending write is dropped.
    accept('{32'h0000_0099, 3'd0, 8'd3, 1'b0, NO_BANK, 8'd0, 1'b0, 0});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(1);
    drain('{3'd0, 8'd3, 32'h0000_0042, 1'b0});
    idle(1);

    // Drain request during reset must not produce dr_valid.
    reset   = 1'b1;
    dr_req  = 1'b1;
    dr_bank = 3'd0;
    dr_addr = 8'd0;
    tick();
    $display("reset_drain dr_valid=%0b", dr_valid);
    check("reset_clears_dr_valid", {31'd0, dr_valid}, 32'd0);
    dr_req = 1'b0;
    reset  = 1'b0;
    idle(3);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
